// File: rtl/collision_detect.sv
// -----------------------------------------------------------------------------
// collision_detect
//   Reads the object-descriptor bus written by update_player and the obstacle
//   updaters. It unpacks the player descriptor and NUM_OBS obstacle
//   descriptors and tests each obstacle's bounding box against the player's.
//   It also runs the game-state FSM (IDLE/RUN/HIT/OVER) and the score counter.
//   game_over goes back to the updaters as their pause input.
//
// Ports
//   clk3       in   1                  game tick clock
//   reset      in   1                  asynchronous, active-low reset
//   start      in   1                  game started (same as update_player)
//   pause      in   1                  freezes scoring and hit confirmation
//   player     in   `DATALEN           player descriptor
//   obs_bus    in   NUM_OBS*`DATALEN   obstacle i at [i*`DATALEN +: `DATALEN]
//   hit        out  1                  one-cycle pulse on RUN->HIT
//   hit_idx    out  $clog2(NUM_OBS)+1  lowest obstacle index behind the hit
//   game_over  out  1                  high in HIT and OVER
//   running    out  1                  high in RUN
//   score      out  SCORE_W            current score, saturating
// -----------------------------------------------------------------------------

`ifndef DATALEN
`define DATATYPESTART   0
`define DATATYPELEN     4
`define DATAXSTART      4
`define DATAYSTART      14
`define DATAWIDTHSTART  24
`define DATAHEIGHTSTART 34
`define DATAPOSLEN      10
`define DATALEN         44
`define PLAYERTYPE      4'd1
`endif

module collision_detect #(
  parameter int NUM_OBS   = 3,
  parameter int CONFIRM   = 2,
  parameter int HIT_HOLD  = 30,
  parameter int SCORE_DIV = 6,
  parameter int SCORE_W   = 14
) (
  input  logic                          clk3,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          pause,
  input  logic [`DATALEN-1:0]           player,
  input  logic [NUM_OBS*`DATALEN-1:0]   obs_bus,
  output logic                          hit,
  output logic [$clog2(NUM_OBS):0]      hit_idx,
  output logic                          game_over,
  output logic                          running,
  output logic [SCORE_W-1:0]            score
);

  localparam int IDX_W  = $clog2(NUM_OBS) + 1;
  localparam int HOLD_W = $clog2(HIT_HOLD) + 1;
  localparam int DIV_W  = $clog2(SCORE_DIV + 1);
  localparam int PW     = `DATAPOSLEN;

  localparam logic [3:0]         CNT_LAST  = 4'(CONFIRM - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HIT_HOLD - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCORE_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [`DATALEN-1:0]         r_player;
  logic [NUM_OBS*`DATALEN-1:0] r_obs;
  logic [NUM_OBS-1:0]          w_ov, r_ov;
  logic                        w_any_ov;
  logic [IDX_W-1:0]            w_first;
  logic [3:0]                  r_cnt;
  logic [HOLD_W-1:0]           r_hold;
  logic [DIV_W-1:0]            r_div;
  logic [SCORE_W-1:0]          r_score;
  logic                        r_hit, w_hit_nxt;
  logic [IDX_W-1:0]            r_hit_idx;
  logic                        w_confirm;

  // ---------------------------------------------------------------------------
  // Stage 1: register the raw descriptors.
  // NOTE: the pipeline registers are reset like any other state, so no stale
  // overlap can appear in the first cycles after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so that every
      // register samples the values from before the edge.
      r_player <= '0;
      r_obs    <= '0;
    end else begin
      r_player <= player;
      r_obs    <= obs_bus;
    end
  end

  // Player fields are widened by one bit so that x+w and y+h never wrap.
  logic           w_ptype_ok;
  logic [PW:0]    w_px, w_py, w_px_end, w_py_end;

  assign w_ptype_ok = (r_player[`DATATYPESTART +: `DATATYPELEN] == `PLAYERTYPE);
  assign w_px       = {1'b0, r_player[`DATAXSTART      +: PW]};
  assign w_py       = {1'b0, r_player[`DATAYSTART      +: PW]};
  assign w_px_end   = w_px + {1'b0, r_player[`DATAWIDTHSTART  +: PW]};
  assign w_py_end   = w_py + {1'b0, r_player[`DATAHEIGHTSTART +: PW]};

  // Obstacle type is carried on the bus but takes no part in the overlap test.
  logic [NUM_OBS-1:0] w_unused_type;

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs
    logic [PW-1:0] w_ow, w_oh;
    logic [PW:0]   w_ox, w_oy, w_ox_end, w_oy_end;

    assign w_ow     = r_obs[g*`DATALEN + `DATAWIDTHSTART  +: PW];
    assign w_oh     = r_obs[g*`DATALEN + `DATAHEIGHTSTART +: PW];
    assign w_ox     = {1'b0, r_obs[g*`DATALEN + `DATAXSTART +: PW]};
    assign w_oy     = {1'b0, r_obs[g*`DATALEN + `DATAYSTART +: PW]};
    assign w_ox_end = w_ox + {1'b0, w_ow};
    assign w_oy_end = w_oy + {1'b0, w_oh};

    assign w_unused_type[g] = ^r_obs[g*`DATALEN + `DATATYPESTART +: `DATATYPELEN];

    // Strict '<' means boxes that only share an edge do not overlap; a zero
    // width or height marks an empty slot.
    assign w_ov[g] = w_ptype_ok && (w_ow != '0) && (w_oh != '0) &&
                     (w_px < w_ox_end) && (w_ox < w_px_end) &&
                     (w_py < w_oy_end) && (w_oy < w_py_end);
  end

  // Stage 2: register per-obstacle overlap flags.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) r_ov <= '0;
    else        r_ov <= w_ov;
  end

  assign w_any_ov = |r_ov;

  // Lowest overlapping obstacle. The scan runs downward so the lowest index
  // is written last.
  always_comb begin
    // NOTE: give every always_comb output a default first; otherwise a path
    // that skips the assignment infers a latch.
    w_first = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (r_ov[i]) w_first = IDX_W'(i);
    end
  end

  // This evaluation completes CONFIRM consecutive overlapping evaluations.
  assign w_confirm = (r_state == S_RUN) && w_any_ov && !pause && (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Game-state FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!start) begin
          w_state_nxt = S_IDLE;
        end else if (w_confirm) begin
          w_state_nxt = S_HIT;
          w_hit_nxt   = 1'b1;
        end
      end
      S_HIT: begin
        if (!start)                   w_state_nxt = S_IDLE;
        else if (r_hold == HOLD_LAST) w_state_nxt = S_OVER;
      end
      S_OVER: if (!start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Confirm counter, HIT dwell counter, hit pulse and hit index.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_hold    <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      r_hit <= w_hit_nxt;
      if (w_hit_nxt) r_hit_idx <= w_first;

      // A gap in overlap always clears the count, even while paused.
      if (r_state != S_RUN || !w_any_ov || w_confirm) r_cnt <= '0;
      else if (!pause)                                 r_cnt <= r_cnt + 4'd1;

      // HIT dwell ignores pause.
      if (r_state == S_HIT) r_hold <= r_hold + HOLD_W'(1);
      else                  r_hold <= '0;
    end
  end

  // Score: SCORE_DIV unpaused RUN cycles per point, saturating. The score
  // is cleared on entry to RUN and held in every other state.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      r_div   <= '0;
      r_score <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_div   <= '0;
      r_score <= '0;
    end else if (r_state == S_RUN) begin
      if (!pause) begin
        if (r_div == DIV_LAST) begin
          r_div <= '0;
          if (r_score != SCORE_MAX) r_score <= r_score + SCORE_W'(1);
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
    end else begin
      r_div <= '0;
    end
  end

  assign hit       = r_hit;
  assign hit_idx   = r_hit_idx;
  assign running   = (r_state == S_RUN);
  assign game_over = (r_state == S_HIT) || (r_state == S_OVER);
  assign score     = r_score;

endmodule

// File: tb/tb_collision_detect.sv
// -----------------------------------------------------------------------------
// tb_collision_detect
//   Directed testbench for collision_detect with its default parameters
//   (NUM_OBS=3, CONFIRM=2, HIT_HOLD=30, SCORE_DIV=6, SCORE_W=14).
//   Inputs change 1 ns after the rising edge of clk3, and outputs are
//   sampled at the same point. m_cnt counts the unpaused RUN edges, so the
//   expected score is m_cnt/6.
// -----------------------------------------------------------------------------

`ifndef DATALEN
`define DATATYPESTART   0
`define DATATYPELEN     4
`define DATAXSTART      4
`define DATAYSTART      14
`define DATAWIDTHSTART  24
`define DATAHEIGHTSTART 34
`define DATAPOSLEN      10
`define DATALEN         44
`define PLAYERTYPE      4'd1
`endif

module tb_collision_detect;

  localparam int DL = `DATALEN;

  logic            clk3 = 1'b0;
  logic            reset;
  logic            start;
  logic            pause;
  logic [DL-1:0]   player;
  logic [3*DL-1:0] obs_bus;
  logic            hit;
  logic [2:0]      hit_idx;
  logic            game_over;
  logic            running;
  logic [13:0]     score;

  int n_vec  = 0;
  int n_miss = 0;
  int m_cnt  = 0;
  bit m_run  = 1'b0;

  collision_detect dut (
    .clk3      (clk3),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .player    (player),
    .obs_bus   (obs_bus),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .game_over (game_over),
    .running   (running),
    .score     (score)
  );

  always #5 clk3 = ~clk3;

  function automatic logic [DL-1:0] mk(input int t, input int x, input int y,
                                       input int w, input int h);
    logic [DL-1:0] d;
    d = '0;
    d[`DATATYPESTART   +: `DATATYPELEN] = 4'(t);
    d[`DATAXSTART      +: `DATAPOSLEN]  = 10'(x);
    d[`DATAYSTART      +: `DATAPOSLEN]  = 10'(y);
    d[`DATAWIDTHSTART  +: `DATAPOSLEN]  = 10'(w);
    d[`DATAHEIGHTSTART +: `DATAPOSLEN]  = 10'(h);
    return d;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk3);
      if (m_run && !pause) m_cnt++;
      #1;
    end
  endtask

  task automatic set_obs(input int i, input logic [DL-1:0] d);
    obs_bus[i*DL +: DL] = d;
  endtask

  task automatic test_reset;
    reset   = 1'b0;
    start   = 1'b0;
    pause   = 1'b0;
    player  = mk(1, 40, 100, 20, 20);
    obs_bus = '0;
    set_obs(0, mk(2, 200, 100, 20, 20));
    #12;
    n_vec++; if (hit !== 1'b0)       begin n_miss++; $display("FAIL reset_hit: got %b want 0", hit); end
    n_vec++; if (hit_idx !== 3'd0)   begin n_miss++; $display("FAIL reset_hit_idx: got %0d want 0", hit_idx); end
    n_vec++; if (game_over !== 1'b0) begin n_miss++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    n_vec++; if (running !== 1'b0)   begin n_miss++; $display("FAIL reset_running: got %b want 0", running); end
    n_vec++; if (score !== 14'd0)    begin n_miss++; $display("FAIL reset_score: got %0d want 0", score); end
    @(posedge clk3); #1;
    reset = 1'b1;
    tick(3);
    n_vec++; if (running !== 1'b0) begin n_miss++; $display("FAIL idle_no_start: running got %b want 0", running); end
  endtask

  task automatic test_run_score;
    start = 1'b1;
    tick(1);
    m_run = 1'b1; m_cnt = 0;
    n_vec++; if (running !== 1'b1) begin n_miss++; $display("FAIL run_entry: running got %b want 1", running); end
    n_vec++; if (score !== 14'd0)  begin n_miss++; $display("FAIL run_entry_score: got %0d want 0", score); end
    tick(59);
    n_vec++; if (score !== 14'd9)  begin n_miss++; $display("FAIL score_59: got %0d want 9", score); end
    tick(1);
    n_vec++; if (score !== 14'd10) begin n_miss++; $display("FAIL score_60: got %0d want 10", score); end
    n_vec++; if ({hit, game_over, running} !== 3'b001)
      begin n_miss++; $display("FAIL run_flags: hit/over/run got %b want 001", {hit, game_over, running}); end
  endtask

  task automatic test_overlap_hit;
    set_obs(0, mk(2, 50, 100, 20, 20));
    for (int k = 0; k < 3; k++) begin
      tick(1);
      n_vec++; if (hit !== 1'b0) begin n_miss++; $display("FAIL early_hit cycle %0d: got %b want 0", k + 1, hit); end
    end
    tick(1);
    m_run = 1'b0;
    n_vec++; if (hit !== 1'b1)       begin n_miss++; $display("FAIL hit_pulse: got %b want 1", hit); end
    n_vec++; if (hit_idx !== 3'd0)   begin n_miss++; $display("FAIL hit_idx0: got %0d want 0", hit_idx); end
    n_vec++; if (game_over !== 1'b1) begin n_miss++; $display("FAIL hit_game_over: got %b want 1", game_over); end
    n_vec++; if (running !== 1'b0)   begin n_miss++; $display("FAIL hit_running: got %b want 0", running); end
    n_vec++; if (score !== 14'd10)   begin n_miss++; $display("FAIL hit_score: got %0d want 10", score); end
    tick(1);
    n_vec++; if (hit !== 1'b0)       begin n_miss++; $display("FAIL hit_one_cycle: got %b want 0", hit); end
  endtask

  task automatic test_over_restart;
    tick(28);
    n_vec++; if (game_over !== 1'b1) begin n_miss++; $display("FAIL hold_29: game_over got %b want 1", game_over); end
    tick(11);
    n_vec++; if ({hit, game_over, running} !== 3'b010)
      begin n_miss++; $display("FAIL over_flags: hit/over/run got %b want 010", {hit, game_over, running}); end
    n_vec++; if (score !== 14'd10) begin n_miss++; $display("FAIL over_score: got %0d want 10", score); end
    set_obs(0, mk(2, 200, 100, 20, 20));
    start = 1'b0;
    tick(1);
    n_vec++; if ({game_over, running} !== 2'b00)
      begin n_miss++; $display("FAIL over_to_idle: over/run got %b want 00", {game_over, running}); end
    n_vec++; if (score !== 14'd10) begin n_miss++; $display("FAIL idle_score_kept: got %0d want 10", score); end
    tick(3);
    start = 1'b1;
    tick(1);
    m_run = 1'b1; m_cnt = 0;
    n_vec++; if (running !== 1'b1) begin n_miss++; $display("FAIL restart_running: got %b want 1", running); end
    n_vec++; if (score !== 14'd0)  begin n_miss++; $display("FAIL restart_score: got %0d want 0", score); end
  endtask

  task automatic test_edge_empty;
    set_obs(0, mk(2, 60, 100, 20, 20));  // right edge touches the player
    set_obs(1, mk(2, 40, 100, 0, 20));   // zero-width slot over the player
    set_obs(2, mk(2, 40, 80, 20, 20));   // bottom edge touches the player's top
    for (int k = 0; k < 12; k++) begin
      tick(1);
      n_vec++; if ({hit, running} !== 2'b01)
        begin n_miss++; $display("FAIL edge_empty cycle %0d: hit/run got %b want 01", k, {hit, running}); end
    end
    // An overlapping box does not hit when the descriptor is not the player type.
    player = mk(2, 40, 100, 20, 20);
    set_obs(0, mk(2, 50, 100, 20, 20));
    for (int k = 0; k < 8; k++) begin
      tick(1);
      n_vec++; if ({hit, running} !== 2'b01)
        begin n_miss++; $display("FAIL wrong_type cycle %0d: hit/run got %b want 01", k, {hit, running}); end
    end
    player = mk(1, 40, 100, 20, 20);
    set_obs(0, mk(2, 200, 100, 20, 20));
    set_obs(1, '0);
    set_obs(2, '0);
    tick(3);
    n_vec++; if (score !== 14'(m_cnt / 6))
      begin n_miss++; $display("FAIL edge_score: got %0d want %0d", score, m_cnt / 6); end
  endtask

  task automatic test_transient_pause;
    set_obs(0, mk(2, 50, 100, 20, 20));
    tick(1);
    set_obs(0, mk(2, 200, 100, 20, 20));
    for (int k = 0; k < 6; k++) begin
      tick(1);
      n_vec++; if ({hit, running} !== 2'b01)
        begin n_miss++; $display("FAIL one_cycle_overlap %0d: hit/run got %b want 01", k, {hit, running}); end
    end
    // Overlap long enough to bring the count to CONFIRM-1, then pause.
    set_obs(0, mk(2, 50, 100, 20, 20));
    tick(3);
    n_vec++; if (hit !== 1'b0) begin n_miss++; $display("FAIL pre_pause: hit got %b want 0", hit); end
    pause = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      n_vec++; if ({hit, running} !== 2'b01)
        begin n_miss++; $display("FAIL paused_overlap %0d: hit/run got %b want 01", k, {hit, running}); end
      n_vec++; if (score !== 14'(m_cnt / 6))
        begin n_miss++; $display("FAIL paused_score %0d: got %0d want %0d", k, score, m_cnt / 6); end
    end
    set_obs(0, mk(2, 200, 100, 20, 20));
    tick(3);
    pause = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      n_vec++; if ({hit, running} !== 2'b01)
        begin n_miss++; $display("FAIL post_pause %0d: hit/run got %b want 01", k, {hit, running}); end
    end
    n_vec++; if (score !== 14'(m_cnt / 6))
      begin n_miss++; $display("FAIL post_pause_score: got %0d want %0d", score, m_cnt / 6); end
  endtask

  task automatic test_multi_idx_reset;
    set_obs(1, mk(2, 45, 105, 10, 10));
    set_obs(2, mk(2, 30, 90, 15, 15));
    tick(3);
    n_vec++; if (hit !== 1'b0) begin n_miss++; $display("FAIL multi_early: hit got %b want 0", hit); end
    tick(1);
    m_run = 1'b0;
    n_vec++; if (hit !== 1'b1)     begin n_miss++; $display("FAIL multi_hit: got %b want 1", hit); end
    n_vec++; if (hit_idx !== 3'd1) begin n_miss++; $display("FAIL multi_hit_idx: got %0d want 1", hit_idx); end
    n_vec++; if (score !== 14'(m_cnt / 6))
      begin n_miss++; $display("FAIL multi_score: got %0d want %0d", score, m_cnt / 6); end
    // Dropping start while in HIT returns to IDLE on the next edge.
    start = 1'b0;
    tick(1);
    n_vec++; if ({game_over, running} !== 2'b00)
      begin n_miss++; $display("FAIL hit_abort: over/run got %b want 00", {game_over, running}); end
    set_obs(1, '0);
    set_obs(2, '0);
    tick(3);
    start = 1'b1;
    tick(1);
    m_run = 1'b1; m_cnt = 0;
    tick(20);
    n_vec++; if (score !== 14'd3) begin n_miss++; $display("FAIL pre_reset_score: got %0d want 3", score); end
    // Asynchronous reset asserted mid-cycle.
    #2;
    reset = 1'b0;
    #1;
    m_run = 1'b0;
    n_vec++; if ({hit, game_over, running} !== 3'b000)
      begin n_miss++; $display("FAIL async_reset_flags: hit/over/run got %b want 000", {hit, game_over, running}); end
    n_vec++; if (hit_idx !== 3'd0) begin n_miss++; $display("FAIL async_reset_idx: got %0d want 0", hit_idx); end
    n_vec++; if (score !== 14'd0)  begin n_miss++; $display("FAIL async_reset_score: got %0d want 0", score); end
    reset = 1'b1;
    tick(1);
    n_vec++; if ({running, score} !== {1'b1, 14'd0})
      begin n_miss++; $display("FAIL post_reset_run: run %b score %0d want 1 0", running, score); end
  endtask

  initial begin
    test_reset();
    test_run_score();
    test_overlap_hit();
    test_over_restart();
    test_edge_empty();
    test_transient_pause();
    test_multi_idx_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
